// File: rtl/cv32e40x_rf_write_arbiter.sv
// Register file write-port arbiter: fixed-priority requester 0, round-robin for the rest,
// same-address conflict stalls and two-cycle pair splitting when only one write port exists.
module cv32e40x_rf_write_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int WPORTS  = 2,
  parameter int DATA_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_pair_i,
  input  logic [NUM_REQ-1:0][4:0]       req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata_lo_i,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata_hi_i,
  output logic [WPORTS-1:0][4:0]        waddr_o,
  output logic [WPORTS-1:0][DATA_W-1:0] wdata_o,
  output logic [WPORTS-1:0]             we_o,
  output logic                          busy_o
);

  localparam int ADDR_W = 5;
  localparam int IDX_W  = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic {IDLE, PAIR_HI} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   lock_q, lock_d;
  logic [NUM_REQ-1:0] ready;
  logic [WPORTS-1:0]  we;
  logic               split_start;

  int                 pos;
  int                 used;
  int                 cost;
  logic [IDX_W-1:0]   k;
  logic [ADDR_W-1:0]  a_lo;
  logic [ADDR_W-1:0]  a_hi;
  logic [31:0]        taken;
  logic               stop;
  logic               pair;
  logic               conflict;
  logic               fits;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return IDX_W'(1);
    return idx + IDX_W'(1);
  endfunction

  always_comb begin
    state_d     = IDLE;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    ready       = '0;
    we          = '0;
    waddr_o     = '0;
    wdata_o     = '0;
    split_start = 1'b0;
    used        = 0;
    cost        = 1;
    pos         = 0;
    k           = '0;
    a_lo        = '0;
    a_hi        = '0;
    taken       = '0;
    stop        = 1'b0;
    pair        = 1'b0;
    conflict    = 1'b0;
    fits        = 1'b0;

    if (state_q == PAIR_HI) begin
      // Second half of a split pair owns the port exclusively.
      we[0]          = 1'b1;
      waddr_o[0]     = {req_addr_i[lock_q][ADDR_W-1:1], 1'b1};
      wdata_o[0]     = req_wdata_hi_i[lock_q];
      ready[lock_q]  = 1'b1;
      if (lock_q != '0) rr_ptr_d = rr_next(lock_q);
    end else begin
      for (int j = 0; j < NUM_REQ; j++) begin
        pos = (j == 0) ? 0 : int'(rr_ptr_q) + j - 1;
        if (pos >= NUM_REQ) pos = pos - (NUM_REQ - 1);
        k        = IDX_W'(pos);
        pair     = req_pair_i[k];
        cost     = pair ? 2 : 1;
        a_lo     = pair ? {req_addr_i[k][ADDR_W-1:1], 1'b0} : req_addr_i[k];
        a_hi     = {req_addr_i[k][ADDR_W-1:1], 1'b1};
        conflict = taken[a_lo] || (pair && taken[a_hi]);
        fits     = (used + cost <= WPORTS) || (WPORTS == 1 && pair && used == 0);
        if (!stop && req_valid_i[k]) begin
          // No bypass: the first candidate that cannot go ends granting for this cycle.
          if (!fits || conflict) begin
            stop = 1'b1;
          end else begin
            taken[a_lo] = 1'b1;
            if (pair) taken[a_hi] = 1'b1;
            for (int p = 0; p < WPORTS; p++) begin
              if (p == used) begin
                we[p]      = (a_lo != '0);
                waddr_o[p] = a_lo;
                wdata_o[p] = req_wdata_lo_i[k];
              end
              if (pair && p == used + 1) begin
                we[p]      = 1'b1;
                waddr_o[p] = a_hi;
                wdata_o[p] = req_wdata_hi_i[k];
              end
            end
            if (pair && WPORTS == 1) begin
              split_start = 1'b1;
              state_d     = PAIR_HI;
              lock_d      = k;
              stop        = 1'b1;
            end else begin
              ready[k] = 1'b1;
              if (k != '0) rr_ptr_d = rr_next(k);
            end
            used = used + cost;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= IDX_W'(1);
      lock_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      lock_q   <= lock_d;
    end
  end

  assign req_ready_o = rst_n ? ready : '0;
  assign we_o        = rst_n ? we : '0;
  assign busy_o      = rst_n && (state_q == PAIR_HI || split_start);

  // A requester must hold valid until it has been acknowledged.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold_chk
    hold_valid_a: assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid_i[g] && !req_ready_o[g]) |=> req_valid_i[g]);
  end

endmodule

// File: tb/tb_cv32e40x_rf_write_arbiter.sv
// Bench for cv32e40x_rf_write_arbiter: directed scenarios on a 2-port and a 1-port instance,
// then random traffic compared cycle by cycle against a list-based reference model.
module tb_cv32e40x_rf_write_arbiter;

  localparam int NREQ = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]       v2, p2, r2;
  logic [2:0][4:0]  a2;
  logic [2:0][31:0] l2, h2;
  logic [1:0][4:0]  wa2;
  logic [1:0][31:0] wd2;
  logic [1:0]       we2;
  logic             b2;

  logic [2:0]       v1, p1, r1;
  logic [2:0][4:0]  a1;
  logic [2:0][31:0] l1, h1;
  logic [0:0][4:0]  wa1;
  logic [0:0][31:0] wd1;
  logic [0:0]       we1;
  logic             b1;

  int n_asrt = 0;
  int n_fail = 0;

  cv32e40x_rf_write_arbiter #(.NUM_REQ(NREQ), .WPORTS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(v2), .req_ready_o(r2), .req_pair_i(p2),
    .req_addr_i(a2), .req_wdata_lo_i(l2), .req_wdata_hi_i(h2),
    .waddr_o(wa2), .wdata_o(wd2), .we_o(we2), .busy_o(b2));

  cv32e40x_rf_write_arbiter #(.NUM_REQ(NREQ), .WPORTS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(v1), .req_ready_o(r1), .req_pair_i(p1),
    .req_addr_i(a1), .req_wdata_lo_i(l1), .req_wdata_hi_i(h1),
    .waddr_o(wa1), .wdata_o(wd1), .we_o(we1), .busy_o(b1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: build the grant order list, then walk it spending port slots and
  // remembering the addresses already written this cycle.
  task automatic model(input int wp, input int rr, input bit hi, input int lock,
      input logic [2:0] v, input logic [2:0] p, input logic [2:0][4:0] a,
      input logic [2:0][31:0] lo, input logic [2:0][31:0] hd,
      output logic [2:0] rdy, output logic [1:0] we, output logic [1:0][4:0] wa,
      output logic [1:0][31:0] wd, output bit bsy,
      output int nrr, output bit nhi, output int nlock);
    int order[$];
    int taken[$];
    int used, k, n;
    int t[2];
    logic [31:0] dv[2];
    bit done, clash;
    rdy = '0; we = '0; wa = '0; wd = '0;
    bsy = hi; nrr = rr; nhi = 1'b0; nlock = lock; used = 0; done = 1'b0;
    if (hi) begin
      wa[0] = a[lock] | 5'd1;
      wd[0] = hd[lock];
      we[0] = 1'b1;
      rdy[lock] = 1'b1;
      if (lock > 0) nrr = (lock == NREQ - 1) ? 1 : lock + 1;
    end else begin
      order.push_back(0);
      for (int j = 0; j < NREQ - 1; j++) order.push_back(1 + ((rr - 1 + j) % (NREQ - 1)));
      foreach (order[i]) begin
        k = order[i];
        if (!done && v[k]) begin
          n = p[k] ? 2 : 1;
          t[0] = p[k] ? (int'(a[k]) / 2) * 2 : int'(a[k]);
          t[1] = (int'(a[k]) / 2) * 2 + 1;
          dv[0] = lo[k];
          dv[1] = hd[k];
          clash = 1'b0;
          for (int w = 0; w < n; w++)
            foreach (taken[q]) if (taken[q] == t[w]) clash = 1'b1;
          if (clash || (used + n > wp && !(wp == 1 && n == 2 && used == 0))) begin
            done = 1'b1;
          end else if (wp == 1 && n == 2) begin
            wa[0] = 5'(t[0]); wd[0] = dv[0]; we[0] = (t[0] != 0);
            bsy = 1'b1; nhi = 1'b1; nlock = k; done = 1'b1;
          end else begin
            for (int w = 0; w < n; w++) begin
              wa[used] = 5'(t[w]); wd[used] = dv[w]; we[used] = (t[w] != 0);
              taken.push_back(t[w]);
              used++;
            end
            rdy[k] = 1'b1;
            if (k > 0) nrr = (k == NREQ - 1) ? 1 : k + 1;
          end
        end
      end
    end
  endtask

  task automatic drive(inout logic [2:0] v, inout logic [2:0] p, inout logic [2:0][4:0] a,
      inout logic [2:0][31:0] l, inout logic [2:0][31:0] h, input logic [2:0] rdy, input bit issue);
    for (int k = 0; k < NREQ; k++) begin
      if (!v[k] || rdy[k]) begin
        if (issue && $urandom_range(0, 2) != 0) begin
          v[k] = 1'b1;
          p[k] = ($urandom_range(0, 3) == 0);
          a[k] = 5'($urandom_range(0, 7));
          l[k] = $urandom;
          h[k] = $urandom;
        end else begin
          v[k] = 1'b0;
        end
      end
    end
  endtask

  logic [2:0]       e_r;
  logic [1:0]       e_we;
  logic [1:0][4:0]  e_wa;
  logic [1:0][31:0] e_wd;
  bit               e_b;
  int m2_rr, m2_lock, m1_rr, m1_lock, n_rr, n_lock;
  bit m2_hi, m1_hi, n_hi;
  logic [2:0] x2_r, x1_r;

  initial begin
    rst_n = 1'b0;
    v2 = '0; p2 = '0; a2 = '0; l2 = '0; h2 = '0;
    v1 = '0; p1 = '0; a1 = '0; l1 = '0; h1 = '0;
    #12;
    chk("rst_ready2", r2, 3'b000);
    chk("rst_we2", we2, 2'b00);
    chk("rst_busy1", b1, 1'b0);
    chk("rst_we1", we1, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_we2", we2, 2'b00);
    chk("idle_waddr2", wa2, 10'd0);
    chk("idle_wdata2", wd2, 64'd0);
    next_cycle();

    // Two singles share the two ports in one cycle
    v2 = 3'b011; a2[0] = 5'd5; l2[0] = 32'hA; a2[1] = 5'd6; l2[1] = 32'hB;
    @(negedge clk);
    chk("two_single_ready", r2, 3'b011);
    chk("two_single_we", we2, 2'b11);
    chk("two_single_p0", {wa2[0], wd2[0]}, {5'd5, 32'hA});
    chk("two_single_p1", {wa2[1], wd2[1]}, {5'd6, 32'hB});
    next_cycle();
    v2 = '0;

    // Pair at rd=1: x0 slot consumed with no write enable, x1 written
    v2 = 3'b001; p2[0] = 1'b1; a2[0] = 5'd1; l2[0] = 32'h10; h2[0] = 32'h11;
    @(negedge clk);
    chk("pair_x1_ready", r2, 3'b001);
    chk("pair_x1_we", we2, 2'b10);
    chk("pair_x1_addr", {wa2[1], wa2[0]}, {5'd1, 5'd0});
    chk("pair_x1_data", wd2[1], 32'h11);
    next_cycle();
    v2 = '0;

    // Pair from req0 fills both ports, req1 waits one cycle
    v2 = 3'b011; p2[0] = 1'b1; a2[0] = 5'd8; l2[0] = 32'h1; h2[0] = 32'h2;
    p2[1] = 1'b0; a2[1] = 5'd12; l2[1] = 32'hC;
    @(negedge clk);
    chk("pair2_c0_ready", r2, 3'b001);
    chk("pair2_c0_we", we2, 2'b11);
    chk("pair2_c0_ports", {wa2[1], wd2[1], wa2[0], wd2[0]}, {5'd9, 32'h2, 5'd8, 32'h1});
    next_cycle();
    v2 = 3'b010; p2[0] = 1'b0;
    @(negedge clk);
    chk("pair2_c1_ready", r2, 3'b010);
    chk("pair2_c1_we", we2, 2'b01);
    chk("pair2_c1_p0", {wa2[0], wd2[0]}, {5'd12, 32'hC});
    next_cycle();
    v2 = '0;

    // Same-address conflict: req2 stalls behind req0 on x7
    v2 = 3'b101; a2[0] = 5'd7; l2[0] = 32'h70; p2[2] = 1'b0; a2[2] = 5'd7; l2[2] = 32'h72;
    @(negedge clk);
    chk("conf_c0_ready", r2, 3'b001);
    chk("conf_c0_we", we2, 2'b01);
    chk("conf_c0_p0", {wa2[0], wd2[0]}, {5'd7, 32'h70});
    next_cycle();
    v2 = 3'b100;
    @(negedge clk);
    chk("conf_c1_ready", r2, 3'b100);
    chk("conf_c1_p0", {wa2[0], wd2[0]}, {5'd7, 32'h72});
    next_cycle();
    v2 = '0;

    // Single-port pair split, req0 arrives during the hi half
    v1 = 3'b010; p1[1] = 1'b1; a1[1] = 5'd11; l1[1] = 32'h3; h1[1] = 32'h4;
    @(negedge clk);
    chk("split_c0_ready", r1, 3'b000);
    chk("split_c0_busy", b1, 1'b1);
    chk("split_c0_p0", {we1, wa1[0], wd1[0]}, {1'b1, 5'd10, 32'h3});
    next_cycle();
    v1 = 3'b011; p1[0] = 1'b0; a1[0] = 5'd3; l1[0] = 32'h33;
    @(negedge clk);
    chk("split_c1_ready", r1, 3'b010);
    chk("split_c1_busy", b1, 1'b1);
    chk("split_c1_p0", {we1, wa1[0], wd1[0]}, {1'b1, 5'd11, 32'h4});
    next_cycle();
    v1 = 3'b001;
    @(negedge clk);
    chk("split_c2_ready", r1, 3'b001);
    chk("split_c2_busy", b1, 1'b0);
    chk("split_c2_p0", {wa1[0], wd1[0]}, {5'd3, 32'h33});
    next_cycle();
    v1 = '0;

    // Round-robin from a fresh reset, req2 writes x0
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    v1 = 3'b110; p1 = '0; a1[1] = 5'd13; l1[1] = 32'h13; a1[2] = 5'd0; l1[2] = 32'h20;
    @(negedge clk);
    chk("rr_c0_ready", r1, 3'b010);
    chk("rr_c0_we", {we1, wa1[0]}, {1'b1, 5'd13});
    next_cycle();
    @(negedge clk);
    chk("rr_c1_ready", r1, 3'b100);
    chk("rr_c1_x0_we", we1, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("rr_c2_ready", r1, 3'b010);
    next_cycle();
    v1 = 3'b100;
    @(negedge clk);
    chk("rr_c3_ready", r1, 3'b100);
    next_cycle();
    v1 = '0;

    // Asynchronous reset in the middle of PAIR_HI
    v1 = 3'b001; p1[0] = 1'b1; a1[0] = 5'd20; l1[0] = 32'h55; h1[0] = 32'h66;
    @(negedge clk);
    chk("rstpair_lo_busy", {b1, r1}, {1'b1, 3'b000});
    next_cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("rstpair_busy", b1, 1'b0);
    chk("rstpair_we", we1, 1'b0);
    chk("rstpair_ready", r1, 3'b000);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rstpair_restart", {b1, r1, we1, wa1[0], wd1[0]}, {1'b1, 3'b000, 1'b1, 5'd20, 32'h55});
    next_cycle();
    @(negedge clk);
    chk("rstpair_hi", {b1, r1, we1, wa1[0], wd1[0]}, {1'b1, 3'b001, 1'b1, 5'd21, 32'h66});
    next_cycle();
    v1 = '0; p1 = '0;

    // Random traffic against the reference model
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    m2_rr = 1; m2_hi = 1'b0; m2_lock = 0;
    m1_rr = 1; m1_hi = 1'b0; m1_lock = 0;
    x2_r = '0; x1_r = '0;
    drive(v2, p2, a2, l2, h2, x2_r, 1'b1);
    drive(v1, p1, a1, l1, h1, x1_r, 1'b1);
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      model(2, m2_rr, m2_hi, m2_lock, v2, p2, a2, l2, h2, e_r, e_we, e_wa, e_wd, e_b,
            n_rr, n_hi, n_lock);
      chk("rnd2_ready", r2, e_r);
      chk("rnd2_we", we2, e_we);
      chk("rnd2_waddr", wa2, e_wa);
      chk("rnd2_wdata", wd2, e_wd);
      chk("rnd2_busy", b2, e_b);
      x2_r = e_r;
      m2_rr = n_rr; m2_hi = n_hi; m2_lock = n_lock;
      model(1, m1_rr, m1_hi, m1_lock, v1, p1, a1, l1, h1, e_r, e_we, e_wa, e_wd, e_b,
            n_rr, n_hi, n_lock);
      chk("rnd1_ready", r1, e_r);
      chk("rnd1_we", we1, e_we[0]);
      chk("rnd1_waddr", wa1, e_wa[0]);
      chk("rnd1_wdata", wd1, e_wd[0]);
      chk("rnd1_busy", b1, e_b);
      x1_r = e_r;
      m1_rr = n_rr; m1_hi = n_hi; m1_lock = n_lock;
      next_cycle();
      drive(v2, p2, a2, l2, h2, x2_r, c < 600);
      drive(v1, p1, a1, l1, h1, x1_r, c < 600);
      if (c >= 600 && v1 == '0 && v2 == '0) break;
    end
    chk("drain_done", {v1, v2}, 6'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
